// File: rtl/mux_sel_pipe_pkg.sv
// Shared constants and helpers for the mux_sel_pipe selector pipeline.
// Holds parameter limits, clog2 and the select-width derivation.
package mux_sel_pipe_pkg;

  localparam int ANCHO_MAX        = 64;
  localparam int NUM_ENTRADAS_MAX = 16;
  localparam int ETAPAS_MAX       = 4;
  localparam int CUENTA_W         = 8;

  typedef logic [CUENTA_W-1:0] cuenta_t;

  function automatic int clog2(input int valor);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < valor) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // A two-input mux still needs one select bit.
  function automatic int sel_width(input int num_entradas);
    int w;
    w = clog2(num_entradas);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_sel_etapa.sv
// One pipeline stage of mux_sel_pipe: valid, sel and data registers.
// Priority: reset, then flush (clears valid), then stall (hold), then load.
module mux_sel_etapa
  import mux_sel_pipe_pkg::*;
#(
  parameter int ANCHO = 32,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [ANCHO-1:0] i_dato,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_sel,
  output logic [ANCHO-1:0] o_dato
);

  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic [ANCHO-1:0] r_dato;

  // Payload only moves with a valid sample, so the last stage keeps the last valid value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_dato  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sel  <= i_sel;
        r_dato <= i_dato;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_sel   = r_sel;
  assign o_dato  = r_dato;

endmodule

// File: rtl/mux_sel_pipe.sv
// Pipelined N-to-1 selector with stall/flush and out-of-range select clamping.
// Define MUX_SEL_PIPE_ERR_EN to build the sticky error flag and saturating error counter.
module mux_sel_pipe
  import mux_sel_pipe_pkg::*;
#(
  parameter int ANCHO        = 32,
  parameter int NUM_ENTRADAS = 4,
  parameter int ETAPAS       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [sel_width(NUM_ENTRADAS)-1:0]   sel,
  input  logic [NUM_ENTRADAS*ANCHO-1:0]        entradas,
  input  logic                                 valid_in,
  input  logic                                 stall,
  input  logic                                 flush,
  output logic [ANCHO-1:0]                     salida,
  output logic                                 valid_out,
  output logic [sel_width(NUM_ENTRADAS)-1:0]   sel_out,
  output logic                                 error_sel,
  output logic [7:0]                           cuenta_err
);

  localparam int               SEL_W   = sel_width(NUM_ENTRADAS);
  localparam logic [SEL_W:0]   NUM_EXT = (SEL_W+1)'(NUM_ENTRADAS);
  localparam logic [SEL_W-1:0] SEL_ULT = SEL_W'(NUM_ENTRADAS - 1);

  if (ANCHO < 1 || ANCHO > ANCHO_MAX || NUM_ENTRADAS < 2 ||
      NUM_ENTRADAS > NUM_ENTRADAS_MAX || ETAPAS < 1 || ETAPAS > ETAPAS_MAX) begin : g_param_err
    $error("mux_sel_pipe: parameter out of range");
  end

  logic                        w_fuera;
  logic [SEL_W-1:0]            w_sel_ef;
  logic [ANCHO-1:0]            w_dato_sel;
  logic [ETAPAS:0]             w_v;
  logic [ETAPAS:0][SEL_W-1:0]  w_s;
  logic [ETAPAS:0][ANCHO-1:0]  w_d;

  // Constant-false when NUM_ENTRADAS is a power of two.
  assign w_fuera = ({1'b0, sel} >= NUM_EXT);

  // Out-of-range selects fall back to the highest input.
  always_comb begin
    w_sel_ef   = w_fuera ? SEL_ULT : sel;
    w_dato_sel = '0;
    for (int k = 0; k < NUM_ENTRADAS; k++) begin
      w_dato_sel = (w_sel_ef == SEL_W'(k)) ? entradas[k*ANCHO +: ANCHO] : w_dato_sel;
    end
  end

  assign w_v[0] = valid_in;
  assign w_s[0] = sel;
  assign w_d[0] = w_dato_sel;

  for (genvar e = 0; e < ETAPAS; e++) begin : g_etapa
    mux_sel_etapa #(
      .ANCHO (ANCHO),
      .SEL_W (SEL_W)
    ) u_etapa (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .flush   (flush),
      .i_valid (w_v[e]),
      .i_sel   (w_s[e]),
      .i_dato  (w_d[e]),
      .o_valid (w_v[e+1]),
      .o_sel   (w_s[e+1]),
      .o_dato  (w_d[e+1])
    );
  end

  assign salida    = w_d[ETAPAS];
  assign sel_out   = w_s[ETAPAS];
  assign valid_out = w_v[ETAPAS];

`ifdef MUX_SEL_PIPE_ERR_EN
  logic    r_error_sel;
  cuenta_t r_cuenta_err;
  logic    w_cuenta;

  assign w_cuenta = valid_in & ~stall & ~flush & w_fuera;

  // Sticky flag and saturating count of accepted out-of-range selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error_sel  <= 1'b0;
      r_cuenta_err <= 8'd0;
    end else if (w_cuenta) begin
      r_error_sel <= 1'b1;
      if (r_cuenta_err != 8'hFF) begin
        r_cuenta_err <= r_cuenta_err + 8'd1;
      end
    end
  end

  assign error_sel  = r_error_sel;
  assign cuenta_err = r_cuenta_err;
`else
  assign error_sel  = 1'b0;
  assign cuenta_err = 8'd0;
`endif

endmodule
